// File: rtl/fifo_pkt_drain_pkg.sv
// Shared types and constants for the FIFO packet drain.
package FIFO_pkg;

  localparam int DATA_WIDTH    = 8;
  localparam int OUT_BUF_DEPTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BODY = 2'd1,
    CSUM = 2'd2
  } state_t;

  // Ring pointer increment for the 3-entry output buffer
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(OUT_BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/fifo_pkt_drain_if.sv
// FIFO read port plus packet stream of the drain block.
interface fifo_pkt_drain_if #(
  parameter int DATA_WIDTH = FIFO_pkg::DATA_WIDTH
);
  logic                  empty;
  logic                  Read_enable;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_sop;
  logic                  m_eop;

  modport master (
    input  empty, data_in, m_ready,
    output Read_enable, m_valid, m_data, m_sop, m_eop
  );

  modport slave (
    output empty, data_in, m_ready,
    input  Read_enable, m_valid, m_data, m_sop, m_eop
  );
endinterface

// File: rtl/fifo_pkt_drain_out_buf.sv
// 3-entry register FIFO that absorbs the upstream read latency.
module pkt_out_buf
  import FIFO_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] mem [OUT_BUF_DEPTH];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;

  // Storage is cleared so the head (and the stream data) reads zero after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < OUT_BUF_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_pkt_drain.sv
// Drains the FIFO read port into fixed-length packets on a valid/ready stream.
// Optional XOR checksum trailer per packet: define PKT_CSUM_EN.
module fifo_pkt_drain
  import FIFO_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_pkg::DATA_WIDTH,
  parameter int PKT_LEN    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_pkt_drain_if.master     bus,
  output logic [CNT_WIDTH-1:0] pkt_count
);

  localparam int WCNT_W = $clog2(PKT_LEN);

  state_t                state, state_nxt;
  logic [WCNT_W-1:0]     wcnt, wcnt_nxt;
  logic                  inflight;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head;
  logic [2:0]            credit_used;
  logic                  xfer;
  logic                  pop;
  logic                  pkt_done;
  logic                  last_body;
`ifdef PKT_CSUM_EN
  logic [DATA_WIDTH-1:0] acc;
`endif

  pkt_out_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (inflight),
    .pop   (pop),
    .data  (bus.data_in),
    .head  (head),
    .occ   (occ)
  );

  // Credit counts the in-flight word so the buffer can never overflow;
  // it depends only on registers, keeping m_ready out of this path.
  assign credit_used     = 3'(occ) + 3'(inflight);
  assign bus.Read_enable = ~reset & ~bus.empty & (credit_used < 3'(OUT_BUF_DEPTH));
  assign xfer            = bus.m_valid & bus.m_ready;
  assign last_body       = (wcnt == WCNT_W'(PKT_LEN - 1));

  always_comb begin
    state_nxt   = state;
    wcnt_nxt    = wcnt;
    bus.m_valid = 1'b0;
    bus.m_data  = head;
    bus.m_sop   = 1'b0;
    bus.m_eop   = 1'b0;
    pop         = 1'b0;
    pkt_done    = 1'b0;
    unique case (state)
      IDLE: begin
        bus.m_valid = (occ != 2'd0);
        bus.m_sop   = 1'b1;
        if (xfer) begin
          pop       = 1'b1;
          state_nxt = BODY;
          wcnt_nxt  = WCNT_W'(1);
        end
      end
      BODY: begin
        bus.m_valid = (occ != 2'd0);
`ifndef PKT_CSUM_EN
        bus.m_eop   = last_body;
`endif
        if (xfer) begin
          pop = 1'b1;
          if (last_body) begin
            wcnt_nxt = '0;
`ifdef PKT_CSUM_EN
            state_nxt = CSUM;
`else
            state_nxt = IDLE;
            pkt_done  = 1'b1;
`endif
          end else begin
            wcnt_nxt = wcnt + WCNT_W'(1);
          end
        end
      end
`ifdef PKT_CSUM_EN
      // Trailer is generated locally, so it never waits on the buffer
      CSUM: begin
        bus.m_valid = 1'b1;
        bus.m_data  = acc;
        bus.m_eop   = 1'b1;
        if (xfer) begin
          state_nxt = IDLE;
          pkt_done  = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wcnt      <= '0;
      inflight  <= 1'b0;
      pkt_count <= '0;
    end else begin
      state    <= state_nxt;
      wcnt     <= wcnt_nxt;
      inflight <= bus.Read_enable;
      if (pkt_done) pkt_count <= pkt_count + CNT_WIDTH'(1);
    end
  end

`ifdef PKT_CSUM_EN
  always_ff @(posedge clk) begin
    if (reset)         acc <= '0;
    else if (pkt_done) acc <= '0;
    else if (pop)      acc <= acc ^ head;
  end
`endif

endmodule

// File: tb/tb_fifo_pkt_drain.sv
// Randomized bench for fifo_pkt_drain against a queue-based packet model.
module tb_fifo_pkt_drain;
  import FIFO_pkg::*;

  localparam int DW = FIFO_pkg::DATA_WIDTH;
  localparam int PL = 4;
  localparam int CW = 16;
`ifdef PKT_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] pkt_count;
  logic [1:0]    pkt_count2;

  fifo_pkt_drain_if #(.DATA_WIDTH(DW)) bus ();
  fifo_pkt_drain_if #(.DATA_WIDTH(DW)) bus2 ();

  // Second instance sees identical inputs; only its counter width differs
  assign bus2.empty   = bus.empty;
  assign bus2.data_in = bus.data_in;
  assign bus2.m_ready = bus.m_ready;

  fifo_pkt_drain #(.DATA_WIDTH(DW), .PKT_LEN(PL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus), .pkt_count(pkt_count)
  );
  fifo_pkt_drain #(.DATA_WIDTH(DW), .PKT_LEN(PL), .CNT_WIDTH(2)) dut_wrap (
    .clk(clk), .reset(reset), .bus(bus2), .pkt_count(pkt_count2)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] acc;
  int  outst, prev_rd, pos, pkts, cyc, first_rd, first_vld, rd_cnt, xf_cnt;
  bit  rdy, stall, rst_req, rnd_rdy, vld_drop;
  bit  hold_v, hold_sop, hold_eop;
  logic [DW-1:0] hold_d;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_clear();
    outst = 0; prev_rd = 0; pos = 0; acc = '0; pkts = 0; hold_v = 0;
    exp_q.delete();
  endtask

  // One clock: drive at negedge, check outputs, then advance the model across the edge
  task automatic step();
    logic          rd, xf;
    logic [DW-1:0] w;
    int            occ_m;
    @(negedge clk);
    if (rnd_rdy) rdy = ($urandom_range(0, 1) == 1);
    reset       = rst_req;
    bus.empty   = (fifo_q.size() == 0) || stall;
    bus.m_ready = rdy;
    #1;
    rd = bus.Read_enable;
    cyc++;
    if (rst_req) begin
      chk("rd_in_reset", 32'(rd), 0);
      @(posedge clk); #1;
      model_clear();
      bus.data_in = DW'($urandom);
      return;
    end
    chk("rd_en", 32'(rd), 32'(!bus.empty && outst < 3));
    occ_m = outst - prev_rd;
    chk("valid", 32'(bus.m_valid), 32'((pos == PL) || (occ_m != 0)));
    chk("pkt_count", 32'(pkt_count), 32'(pkts % (1 << CW)));
    chk("pkt_count_wrap", 32'(pkt_count2), 32'(pkts % 4));
    if (hold_v) begin
      chk("hold_valid", 32'(bus.m_valid), 1);
      chk("hold_data", 32'(bus.m_data), 32'(hold_d));
      chk("hold_sop", 32'(bus.m_sop), 32'(hold_sop));
      chk("hold_eop", 32'(bus.m_eop), 32'(hold_eop));
    end
    if (rd && first_rd < 0) first_rd = cyc;
    if (bus.m_valid && first_vld < 0) first_vld = cyc;
    if (pos > 0 && pos < PL && !bus.m_valid) vld_drop = 1;
    if (rd) rd_cnt++;
    xf = bus.m_valid && bus.m_ready;
    hold_v = bus.m_valid && !bus.m_ready;
    hold_d = bus.m_data; hold_sop = bus.m_sop; hold_eop = bus.m_eop;
    if (xf) begin
      xf_cnt++;
      if (pos < PL) begin
        if (exp_q.size() == 0) begin
          chk("underrun", 1, 0);
        end else begin
          w = exp_q.pop_front();
          chk("data", 32'(bus.m_data), 32'(w));
          acc ^= w;
        end
        chk("sop", 32'(bus.m_sop), 32'(pos == 0));
        chk("eop", 32'(bus.m_eop), 32'(!CSUM_ON && pos == PL - 1));
        outst--;
        if (pos == PL - 1 && !CSUM_ON) begin pos = 0; pkts++; acc = '0; end
        else pos++;
      end else begin
        chk("csum_data", 32'(bus.m_data), 32'(acc));
        chk("csum_sop", 32'(bus.m_sop), 0);
        chk("csum_eop", 32'(bus.m_eop), 1);
        pos = 0; pkts++; acc = '0;
      end
    end
    @(posedge clk); #1;
    if (rd) begin
      w = fifo_q.pop_front();
      bus.data_in = w;
      exp_q.push_back(w);
      outst++;
    end else begin
      bus.data_in = DW'($urandom);
    end
    prev_rd = rd;
  endtask

  task automatic do_reset();
    rst_req = 1; step(); rst_req = 0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || pos != 0) && n < budget) begin
      step(); n++;
    end
    if (n >= budget) chk("drain_timeout", 0, 1);
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(DW'($urandom));
  endtask

  int wrap_exp[5] = '{1, 2, 3, 0, 1};
  int pushed;

  initial begin
    bus.empty = 1; bus.m_ready = 0; bus.data_in = '0;
    rdy = 0; stall = 0; rnd_rdy = 0; vld_drop = 0; cyc = 0; rd_cnt = 0; xf_cnt = 0;
    model_clear();

    do_reset();
    chk("rst_valid", 32'(bus.m_valid), 0);
    chk("rst_sop", 32'(bus.m_sop), 1);
    chk("rst_eop", 32'(bus.m_eop), 0);
    chk("rst_data", 32'(bus.m_data), 0);
    chk("rst_count", 32'(pkt_count), 0);

    // Single packet and first-word latency
    rdy = 1; first_rd = -1; first_vld = -1;
    fifo_q.push_back(8'h11); fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h33); fifo_q.push_back(8'h44);
    drain(40);
    chk("latency", 32'(first_vld - first_rd), 2);
    chk("single_pkts", 32'(pkts), 1);

    // Backpressure: only three words may be pulled while the sink stalls
    rdy = 0; rd_cnt = 0;
    push_words(8);
    repeat (10) step();
    chk("bp_reads", 32'(rd_cnt), 3);
    chk("bp_rd_low", 32'(bus.Read_enable), 0);
    rdy = 1;
    drain(60);
    chk("bp_pkts", 32'(pkts), 3);

    // Starvation mid-packet
    vld_drop = 0;
    fifo_q.push_back(8'h01); fifo_q.push_back(8'h02);
    repeat (7) step();
    fifo_q.push_back(8'h03); fifo_q.push_back(8'h04);
    drain(40);
    chk("starve_drop", 32'(vld_drop), 1);
    chk("starve_pkts", 32'(pkts), 4);

    // Counter wrap on the 2-bit instance
    do_reset();
    for (int k = 0; k < 5; k++) begin
      push_words(PL);
      drain(40);
      chk("wrap", 32'(pkt_count2), 32'(wrap_exp[k]));
    end

    // Reset after two words out with a read still in flight
    xf_cnt = 0;
    push_words(PL);
    for (int n = 0; n < 40 && xf_cnt < 2; n++) step();
    chk("mid_xfers", 32'(xf_cnt), 2);
    do_reset();
    chk("mid_valid", 32'(bus.m_valid), 0);
    chk("mid_count", 32'(pkt_count), 0);
    chk("mid_sop", 32'(bus.m_sop), 1);
    push_words((PL - fifo_q.size() % PL) % PL + PL);
    drain(60);

    // Random traffic, random ready and upstream stalls
    do_reset();
    fifo_q.delete();
    rnd_rdy = 1; pushed = 0;
    while (pushed < 1000) begin
      if ($urandom_range(0, 3) != 0) begin
        fifo_q.push_back(DW'($urandom)); pushed++;
      end
      stall = ($urandom_range(0, 7) == 0);
      step();
    end
    stall = 0;
    drain(6000);
    chk("rand_pkts", 32'(pkts), 1000 / PL);
    chk("rand_count", 32'(pkt_count), 1000 / PL);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_pkt_drain.md
# fifo_pkt_drain

Downstream consumer of the FIFO buffer's read port. It issues `Read_enable` against `empty` and captures the FIFO's registered `data_out` one cycle after each accepted read. It regroups the words into fixed-length packets on a valid/ready stream with start/end markers. It hides the FIFO's one-cycle read latency behind a 3-entry credit-controlled output buffer, so a continuously ready sink sees one word per cycle.

## Interface
Parameters:
- `DATA_WIDTH`, default `FIFO_pkg::DATA_WIDTH`: word width, identical to the FIFO's.
- `PKT_LEN`, default 4: body words per packet, range 2..256.
- `CNT_WIDTH`, default 16: width of the packet counter.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `empty`  in  1: FIFO empty flag.
- `Read_enable`  out  1: read request to the FIFO. Combinational.
- `data_in`  in  DATA_WIDTH: FIFO `data_out`. Valid the cycle after an accepted read.
- `m_valid`  out  1: stream word valid.
- `m_ready`  in  1: sink accepts the word.
- `m_data`  out  DATA_WIDTH: stream word.
- `m_sop`  out  1: first word of a packet.
- `m_eop`  out  1: last word of a packet.
- `pkt_count`  out  CNT_WIDTH: number of completed packets, wraps modulo 2^CNT_WIDTH.

## Operation
- **Read acceptance:** a read is accepted at an edge where `Read_enable` is 1. `Read_enable` already includes `~empty`.
- **Read request:** `Read_enable = ~empty && (occ + inflight < 3)`.
  - `occ` is the buffer occupancy, 0..3.
  - `inflight` is a register set to 1 at an edge with an accepted read, otherwise cleared.
- **Capture:** when `inflight` is 1, `data_in` is written into the buffer at the next edge. The credit rule guarantees the buffer never overflows.
- **Stream handshake:**
  - A transfer occurs at an edge with `m_valid && m_ready`.
  - Once `m_valid` rises, `m_data`, `m_sop` and `m_eop` stay stable until the transfer.
  - `m_valid` never drops without a transfer.
- **State machine `state_t`:**
  - **IDLE:** no word of the current packet has been sent. `m_valid = (occ != 0)`, `m_data` is the buffer head, `m_sop = 1`. Goes to BODY on transfer.
  - **BODY:** `m_valid = (occ != 0)`, `m_sop = 0`. `wcnt` counts body words already sent. The word with `wcnt == PKT_LEN-1` is the last body word.
    - Without the checksum trailer, that word has `m_eop = 1`. Its transfer returns to IDLE, clears `wcnt`, and increments `pkt_count`.
    - With the trailer, its transfer goes to CSUM instead.
  - **CSUM:** exists only with `PKT_CSUM_EN`. See Configuration.
- **Buffer pop:** only body-word transfers pop the buffer.
- **Simultaneous events:** capture and pop in the same edge leave `occ` unchanged.
- **Reset:**
  - Returns to IDLE and clears `occ`, `inflight`, `wcnt`, `pkt_count` and the checksum accumulator.
  - Mid-packet, any partial packet and any in-flight word are discarded. The sink must treat a reset as a packet abort.
- **Reset values:** `m_valid = 0`, `m_sop = 1`, `m_eop = 0`, `m_data = 0`, `pkt_count = 0`. `Read_enable` is 0 during reset regardless of `empty`.

## Timing
- **Latency from an empty block:** `empty` falls in cycle N → `Read_enable = 1` in N → `data_in` valid in N+1 → captured at the end of N+1 → `m_valid = 1` in N+2.
- **Throughput:** with `m_ready` held at 1 and the FIFO non-empty, one body word per cycle.
- **Checksum trailer:** with `PKT_CSUM_EN`, each trailer costs exactly one extra cycle per packet. Reads continue during the trailer cycle while credit allows.
- **Backpressure:** with `m_ready = 0`, at most 3 words are buffered and `Read_enable` stays 0 once `occ + inflight = 3`.
- **Timing path:** there is no combinational path from `m_ready` to `Read_enable`.

## Configuration
- **`PKT_CSUM_EN` defined:**
  - After the last body word transfers, the state goes to CSUM.
  - `m_data` is the XOR of the packet's `PKT_LEN` body words, with `m_sop = 0` and `m_eop = 1`. The body words have `m_eop = 0`.
  - `m_valid = 1` unconditionally in CSUM.
  - The trailer transfer returns to IDLE, increments `pkt_count` and clears the accumulator. The buffer is not popped.
- **`PKT_CSUM_EN` undefined:** there is no CSUM state and no accumulator. The last body word carries `m_eop = 1`.

## Structure
- `FIFO_pkg` holds `DATA_WIDTH`, the new `state_t` enum (IDLE, BODY, CSUM) and the `OUT_BUF_DEPTH = 3` constant.
- Sub-module `pkt_out_buf`: 3-entry register FIFO.
  - Ports: push, pop, data, head, `occ`.
  - Its pointers wrap modulo 3, and it is reset by `reset`.

## Test plan
- **Single packet:** FIFO holds 0x11, 0x22, 0x33, 0x44; `PKT_LEN = 4`; `m_ready = 1` → required response:
  - Four transfers on consecutive cycles, first `m_valid` 2 cycles after the first read.
  - `m_sop` on 0x11 and `m_eop` on 0x44; `pkt_count = 1`.
  - With `PKT_CSUM_EN`, a fifth word 0x44 (the XOR of the four) carrying `m_eop`.
- **Backpressure:** hold `m_ready = 0` with 8 words in the FIFO → exactly 3 reads accepted, then `Read_enable = 0`. Release `m_ready` → all 8 words out in order, none lost or duplicated.
- **Starvation:** the FIFO supplies 0x01, 0x02, goes empty for 5 cycles, then supplies 0x03, 0x04 → required response:
  - `m_valid` drops between packet words 2 and 3, and `Read_enable = 0` while `empty = 1`.
  - One packet with `m_sop` on 0x01 and `m_eop` on 0x04.
- **Reset mid-packet:** assert `reset` for 1 cycle after 2 of 4 words have transferred, with one read in flight → the next cycle shows `m_valid = 0`, `pkt_count = 0` and state IDLE. The next word starts a new packet with `m_sop = 1`.
- **Random ready:** 1000 random words with `m_ready` random at 50% → the stream equals the FIFO write order, `m_eop` appears every `PKT_LEN` words (every `PKT_LEN+1` with `PKT_CSUM_EN`), and `pkt_count` equals 1000/`PKT_LEN`.
- **Counter wrap:** `CNT_WIDTH = 2`, 5 packets → `pkt_count` reads 1, 2, 3, 0, 1 after each packet.
